mcs4_bus_timer: RTL

//  Master timing sequencer for the MCS-4 bus: from one fast clock, generates the two-phase cp1/cp2 clocks and

---
 rtl/mcs4_bus_timer.sv | 91 +++++++++
 1 files changed

// File: rtl/mcs4_bus_timer.sv
// MCS-4 bus master timing: cp1/cp2/sync, one-hot A1..E3 state, CM-ROM strobe, chip reset, run/halt.
// Optional `SINGLE_STEP_EN adds a `step` input that releases one instruction cycle while halted.
module mcs4_bus_timer #(
  parameter int unsigned PHASE_DIV    = 4,
  parameter int unsigned RESET_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        io_cmd,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        cp1,
  output logic        cp2,
  output logic        sync,
  output logic        cm,
  output logic        chip_reset_n,
  output logic [7:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam int unsigned SW = (PHASE_DIV > 2) ? $clog2(PHASE_DIV) : 1;
  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [7:0] {
    A1 = 8'h01, A2 = 8'h02, A3 = 8'h04, M1 = 8'h08,
    M2 = 8'h10, X1 = 8'h20, X2 = 8'h40, E3 = 8'h80
  } mstate_t;

  mstate_t       st_q, st_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic [RW-1:0] rst_cnt;
  logic          io_flag;
  logic          slot_last, release_ok, hold, wrap;
  logic          enter_e3, enter_e2, crn_nxt, e2_io;

  always_comb begin
    slot_last = (slot == SW'(PHASE_DIV - 1));
`ifdef SINGLE_STEP_EN
    release_ok = run | (halted & step);
`else
    release_ok = run;
`endif
    // Halt only parks at the last slot of E3, and never while bus chips are still in reset.
    hold     = slot_last && (st_q == E3) && chip_reset_n && !release_ok;
    wrap     = slot_last && !hold;
    slot_nxt = wrap ? '0 : (hold ? slot : slot + SW'(1));
    st_nxt   = wrap ? mstate_t'({st_q[6:0], st_q[7]}) : st_q;
    enter_e3 = wrap && (st_nxt == E3);
    enter_e2 = wrap && (st_nxt == X2);
    crn_nxt  = chip_reset_n |
               (enter_e3 && (rst_cnt == RW'(RESET_CYCLES - 1)));
    e2_io    = enter_e2 ? io_cmd : io_flag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot         <= '0;
      st_q         <= E3;
      cp1          <= 1'b0;
      cp2          <= 1'b0;
      sync         <= 1'b1;
      cm           <= 1'b0;
      chip_reset_n <= 1'b0;
      halted       <= 1'b0;
      instr_count  <= '0;
      rst_cnt      <= '0;
      io_flag      <= 1'b0;
    end else begin
      slot         <= slot_nxt;
      st_q         <= st_nxt;
      halted       <= hold;
      cp2          <= wrap;
      cp1          <= !hold && (slot_nxt == SW'(PHASE_DIV / 2));
      sync         <= st_nxt[7];
      chip_reset_n <= crn_nxt;
      cm           <= crn_nxt && ((st_nxt == A3) || ((st_nxt == X2) && e2_io));
      if (wrap && (st_nxt == A1))
        instr_count <= instr_count + 16'd1;
      if (enter_e3 && (rst_cnt < RW'(RESET_CYCLES)))
        rst_cnt <= rst_cnt + RW'(1);
      if (enter_e2)
        io_flag <= io_cmd;
    end
  end

  assign state = st_q;

endmodule
